// File: rtl/x_alp_uart_rx.sv
// Oversampling UART receiver (8 data bits, LSB first) with a small receive FIFO.
// Define X_ALP_UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module x_alp_uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        enable_i,
  input  logic [15:0] div_i,
  output logic [7:0]  rdata_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef X_ALP_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e         state_q, state_d;
  logic           sync1_q, sync2_q, rxs;
  logic [15:0]    div_cnt_q, div_cnt_d, div_eff;
  logic           tick;
  logic [OSW-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           push_q, push_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
`ifdef X_ALP_UART_RX_PARITY_EN
  logic           par_bad_q, par_bad_d;
  logic           perr_q, perr_d;
`endif

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    count_q, count_d;
  logic           full, pop, wr;

  assign rxs     = sync2_q;
  assign busy_o  = (state_q != S_IDLE);
  assign div_eff = (div_i == 16'd0) ? 16'd1 : div_i;
  assign tick    = busy_o && (div_cnt_q == div_eff - 16'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Divider sits at zero while idle, so a frame always starts on a fresh tick period.
  always_comb begin
    div_cnt_d = div_cnt_q + 16'd1;
    if (!busy_o || tick) div_cnt_d = 16'd0;
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef X_ALP_UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs && enable_i) begin
          state_d   = S_START;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (os_cnt_q == OS_HALF) begin
            os_cnt_d = '0;
            state_d  = rxs ? S_IDLE : S_DATA;
          end else begin
            os_cnt_d = os_cnt_q + OSW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            shift_d   = {rxs, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef X_ALP_UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + OSW'(1);
          end
        end
      end
`ifdef X_ALP_UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            par_bad_d = ^{shift_q, rxs};
            state_d   = S_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OSW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (!rxs) begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end else begin
              state_d = S_IDLE;
`ifdef X_ALP_UART_RX_PARITY_EN
              if (par_bad_q) perr_d = 1'b1;
              else           push_d = 1'b1;
`else
              push_d = 1'b1;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + OSW'(1);
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Disabling drops any frame in flight silently.
    if (!enable_i) begin
      state_d = S_IDLE;
      push_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef X_ALP_UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef X_ALP_UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef X_ALP_UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // The shift register still holds the finished byte in the push cycle.
  assign full     = (count_q == DEPTH_C);
  assign rvalid_o = (count_q != '0);
  assign pop      = rvalid_o && rready_i;
  assign wr       = push_q && (!full || pop);
  assign ovr_d    = push_q && full && !pop;
  assign rdata_o  = rvalid_o ? mem_q[rptr_q] : 8'h00;

  always_comb begin
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (!wr && pop) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (wr)  wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= shift_q;
  end

  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
`ifdef X_ALP_UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: doc/x_alp_uart_rx.md
X_ALP_UART_RX -- requirements
Module: x_alp_uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: ticks per bit period; shall be even and at least 4.
REQ-002 Parameter FIFO_DEPTH, default 4: receive FIFO entries; shall be a power of two and at least 2.
REQ-003 clk_i  input  1  single clock; all state is clocked on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 rx_i  input  1  serial line, idle high, asynchronous to clk_i.
REQ-006 enable_i  input  1  receiver enable.
REQ-007 div_i  input  16  clk_i cycles per oversample tick; the value 0 shall be treated as 1.
REQ-008 rdata_o  output  8  byte at the FIFO head.
REQ-009 rvalid_o  output  1  FIFO not empty.
REQ-010 rready_i  input  1  consumer accepts the head byte when rvalid_o and rready_i are both high.
REQ-011 frame_err_o  output  1  one-cycle pulse on a stop-bit error.
REQ-012 parity_err_o  output  1  one-cycle pulse on a parity mismatch.
REQ-013 overrun_o  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-014 busy_o  output  1  high in every FSM state except IDLE.

Function
REQ-015 rx_i shall pass through a 2-flop synchronizer; all of the following requirements refer to the synchronized value (rxs).
REQ-016 Tick generator: assert a one-cycle tick every max(div_i,1) cycles; it shall free-run only while busy_o is high, and it shall restart at count 0 on the IDLE->START transition.
REQ-017 FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-018 IDLE -> START when rxs=0 and enable_i=1.
REQ-019 START: at tick OVERSAMPLE/2, rxs=0 -> DATA; rxs=1 -> IDLE (glitch, nothing reported).
REQ-020 DATA: sample rxs every OVERSAMPLE ticks, 8 bits, LSB first; after bit 7 go to PARITY if the macro is defined, otherwise to STOP.
REQ-021 STOP: sample after OVERSAMPLE ticks; rxs=1 -> push the byte and go to IDLE; rxs=0 -> pulse frame_err_o, discard the byte, go to WAIT_HIGH.
REQ-022 WAIT_HIGH -> IDLE when rxs=1; a held-low line (break) shall produce exactly one frame_err_o pulse.
REQ-023 Push shall occur in the cycle after the stop sample tick; rvalid_o shall rise in the following cycle when the FIFO was empty.
REQ-024 FIFO: rdata_o shall show the head entry and rvalid_o shall equal not-empty; a pop occurs when rvalid_o and rready_i are both high.
REQ-025 Push into a full FIFO with no pop in the same cycle: pulse overrun_o, drop the new byte, leave the FIFO contents unchanged.
REQ-026 Push and pop in the same cycle when full: both take effect and no overrun is reported.
REQ-027 Read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-028 enable_i low shall force the FSM to IDLE within one cycle and abandon any partial frame without error; the FIFO contents and the pop path shall be unaffected.
REQ-029 A change of div_i mid-frame is undefined; software changes it only while busy_o is low.

Reset
REQ-030 While rst_i is high: FSM=IDLE; tick counter, bit counter, shift register and FIFO pointers=0; synchronizer flops=1.
REQ-031 Reset output values: rdata_o=0x00, rvalid_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0, busy_o=0.
REQ-032 Reset asserted mid-frame shall discard the partial frame and all FIFO contents.

Configuration
REQ-033 Macro X_ALP_UART_RX_PARITY_EN defined: one even-parity bit follows the data bits and is sampled after OVERSAMPLE ticks.
REQ-034 On parity mismatch: pulse parity_err_o and drop the byte; STOP is still checked, and frame_err_o has priority if the stop bit is also bad.
REQ-035 Macro X_ALP_UART_RX_PARITY_EN undefined: no PARITY state, 10-bit frames, parity_err_o tied to 0; the port list is identical in both builds.

Verification
REQ-036 div_i=1, OVERSAMPLE=16, send 0xA5 with a good stop bit, rready_i=1 -> rdata_o=0xA5 with rvalid_o high for 1 cycle, no error pulses.
REQ-037 rx_i low for 5 cycles, then high (div_i=1) -> FSM returns to IDLE, rvalid_o stays 0, no error pulses.
REQ-038 Send 0x3C with the stop bit held 0, then the line held low for 100 cycles -> exactly one frame_err_o pulse, no push, busy_o high until the line returns high.
REQ-039 rready_i=0, send 5 bytes 0x01..0x05 (FIFO_DEPTH=4) -> one overrun_o pulse on the 5th byte; later reads return 0x01..0x04.
REQ-040 With X_ALP_UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err_o pulses, no push; with parity bit 1 -> 0x07 is pushed.
REQ-041 Drive enable_i low at data bit 3, then high, then send 0x5A -> only 0x5A is received, no error pulses.
